// File: rtl/ghost_sprite_display_if.sv
// Pixel-path bundle for one ghost renderer: scan position, ghost centre, game events and RGB result.
interface ghost_sprite_display_if;
  logic [9:0] x;
  logic [8:0] y;
  logic [9:0] xGhost;
  logic [8:0] yGhost;
  logic       e_fright;
  logic       e_eaten;
  logic       e_home;
  logic       m_hold;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (
    output x, y, xGhost, yGhost, e_fright, e_eaten, e_home, m_hold,
    input  r, g, b
  );

  modport slave (
    input  x, y, xGhost, yGhost, e_fright, e_eaten, e_home, m_hold,
    output r, g, b
  );
endinterface

// File: rtl/ghost_sprite_display.sv
// Square ghost sprite renderer with per-frame position latch, fright/warn/eaten modes and registered RGB.
module ghost_sprite_display #(
  parameter int unsigned HALF          = 1,
  parameter logic [7:0]  RED           = 8'd255,
  parameter logic [7:0]  GRN           = 8'd0,
  parameter logic [7:0]  BLUE          = 8'd0,
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned WARN_FRAMES   = 120,
  parameter int unsigned BLINK_FRAMES  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  ghost_sprite_display_if.slave  bus
);

  localparam int unsigned CW  = $clog2(FRIGHT_FRAMES + 1);
  localparam int unsigned BW  = $clog2(BLINK_FRAMES + 1);
  localparam logic [10:0] H11 = 11'(HALF);

  typedef enum logic [1:0] {ST_NORMAL, ST_FRIGHT, ST_WARN, ST_EATEN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic          origin_prev_q, origin_prev_d;
  logic          pos_valid_q, pos_valid_d;
  logic [9:0]    xl_q, xl_d;
  logic [8:0]    yl_q, yl_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;

  logic          origin, tick;
  logic [CW-1:0] cnt_dec;
  logic [BW-1:0] blink_inc;
  logic [10:0]   xs, ys, xl11, yl11;
  logic          body, eye;
  logic [23:0]   colour;

  always_comb begin
    origin        = (bus.x == '0) && (bus.y == '0);
    tick          = origin && !origin_prev_q;
    origin_prev_d = origin;

    xl_d        = xl_q;
    yl_d        = yl_q;
    pos_valid_d = pos_valid_q;
    if (tick) begin
      xl_d        = bus.xGhost;
      yl_d        = bus.yGhost;
      pos_valid_d = 1'b1;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    blink_d   = blink_q;
    phase_d   = phase_q;
    cnt_dec   = cnt_q - CW'(1);
    blink_inc = blink_q + BW'(1);

    // Events pre-empt the frame-tick countdown; eaten outranks a simultaneous fright restart.
    if (bus.e_eaten && (state_q == ST_FRIGHT || state_q == ST_WARN)) begin
      state_d = ST_EATEN;
    end else if (bus.e_fright && state_q != ST_EATEN) begin
      state_d = ST_FRIGHT;
      cnt_d   = CW'(FRIGHT_FRAMES);
      blink_d = '0;
      phase_d = 1'b0;
    end else if (bus.e_home && state_q == ST_EATEN) begin
      state_d = ST_NORMAL;
      cnt_d   = '0;
    end else if (tick && !bus.m_hold && (state_q == ST_FRIGHT || state_q == ST_WARN)) begin
      cnt_d = cnt_dec;
      if (cnt_dec == '0) begin
        state_d = ST_NORMAL;
        blink_d = '0;
        phase_d = 1'b0;
      end else if (state_q == ST_FRIGHT && cnt_dec == CW'(WARN_FRAMES)) begin
        state_d = ST_WARN;
        blink_d = '0;
        phase_d = 1'b0;
      end else if (state_q == ST_WARN) begin
        if (blink_inc == BW'(BLINK_FRAMES)) begin
          blink_d = '0;
          phase_d = !phase_q;
        end else begin
          blink_d = blink_inc;
        end
      end
    end

    // 11-bit unsigned compare keeps the sprite from wrapping across screen edges.
    xs   = {1'b0, bus.x};
    ys   = {2'b00, bus.y};
    xl11 = {1'b0, xl_q};
    yl11 = {2'b00, yl_q};
    body = (xs + H11 >= xl11) && (xs <= xl11 + H11) &&
           (ys + H11 >= yl11) && (ys <= yl11 + H11);
    eye  = (ys + H11 == yl11) && ((xs + H11 == xl11) || (xs == xl11 + H11));

    colour = '0;
    unique case (state_q)
      ST_NORMAL: if (body) colour = {RED, GRN, BLUE};
      ST_FRIGHT: if (body) colour = 24'h0000FF;
      ST_WARN:   if (body) colour = phase_q ? 24'hFFFFFF : 24'h0000FF;
      ST_EATEN:  if (eye)  colour = 24'hFFFFFF;
      default:   colour = '0;
    endcase
    if (!pos_valid_q) colour = '0;
    {r_d, g_d, b_d} = colour;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_NORMAL;
      cnt_q         <= '0;
      blink_q       <= '0;
      phase_q       <= 1'b0;
      origin_prev_q <= 1'b0;
      pos_valid_q   <= 1'b0;
      xl_q          <= '0;
      yl_q          <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      blink_q       <= blink_d;
      phase_q       <= phase_d;
      origin_prev_q <= origin_prev_d;
      pos_valid_q   <= pos_valid_d;
      xl_q          <= xl_d;
      yl_q          <= yl_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign bus.r = r_q;
  assign bus.g = g_q;
  assign bus.b = b_q;

endmodule

// File: doc/ghost_sprite_display.md
# ghost_sprite_display

- Parametrised ghost sprite renderer for the VGA pixel path: draws a (2·HALF+1)-pixel square ghost centred on the ghost position and outputs one RGB triple per pixel.
- Adds the following over the fixed 3×3 renderer:
  - per-frame position latching, so no tearing occurs mid-frame;
  - a frightened / warning-blink / eaten mode state machine driven by game events;
  - a registered output.
- Sits between the ghost movement logic and the per-pixel colour mux, one instance per ghost.

## Interface
Parameters:
- HALF, 1, sprite half-width in pixels; sprite is (2·HALF+1)×(2·HALF+1)
- RED / GRN / BLUE, 255 / 0 / 0, normal body colour
- FRIGHT_FRAMES, 360, frames spent frightened (FRIGHT + WARN), ≥ WARN_FRAMES+1
- WARN_FRAMES, 120, final frames of fright spent blinking
- BLINK_FRAMES, 15, frames per blink phase in WARN, ≥1

Ports:
- clk  in  1  pixel clock; one (x,y) pixel presented per cycle
- reset  in  1  synchronous, active-high
- x  in  10  current pixel column
- y  in  9  current pixel row
- xGhost  in  10  ghost centre column, live
- yGhost  in  9  ghost centre row, live
- e_fright  in  1  one-cycle pulse: start/restart fright
- e_eaten  in  1  one-cycle pulse: ghost eaten by player
- e_home  in  1  one-cycle pulse: eaten ghost reached home
- m_hold  in  1  level: game paused, freezes all frame timers
- r, g, b  out  8 each  pixel colour, registered

## Operation
**Frame tick**
- tick = (x==0 && y==0) this cycle and not last cycle; a previous-origin flag is registered.
- On tick, xGhost/yGhost are latched and `pos_valid` is set.
- Until the first tick after reset, the output is black.

**Hit test**
- Uses the latched position, computed in 11-bit unsigned, so there is no wrap at screen edges.
- body = (x+HALF ≥ xl) && (x ≤ xl+HALF) && (y+HALF ≥ yl) && (y ≤ yl+HALF).
- eye = (y+HALF == yl) && (x+HALF == xl || x == xl+HALF), i.e. the top-row corner pixels.

**States**
- NORMAL: body → (RED,GRN,BLUE).
- FRIGHT: body → (0,0,255).
- WARN: body → (0,0,255) when phase=0, (255,255,255) when phase=1.
- EATEN: eye → (255,255,255); all other pixels black.
- Any non-hit pixel → (0,0,0).

**Transitions** (priority top to bottom)
- reset → NORMAL, cnt=0, phase=0.
- e_eaten in FRIGHT or WARN → EATEN; ignored elsewhere.
- e_fright in NORMAL, FRIGHT or WARN → FRIGHT, cnt=FRIGHT_FRAMES, phase=0. Ignored in EATEN.
- e_home in EATEN → NORMAL; ignored elsewhere.
- On tick with m_hold=0:
  - in FRIGHT or WARN, cnt decrements;
  - FRIGHT with cnt−1 == WARN_FRAMES → WARN, blink counter cleared, phase=0;
  - WARN blink counter reaching BLINK_FRAMES → phase toggles, counter cleared;
  - cnt−1 == 0 → NORMAL.

**Width and hold rules**
- cnt width = $clog2(FRIGHT_FRAMES+1).
- m_hold=1 freezes cnt, the blink counter and phase.
- Position latching continues during m_hold.

**Simultaneous events**
- An event takes priority over the frame-tick decrement in the same cycle.
- e_fright+tick: load wins, no decrement.
- e_eaten+e_fright: EATEN wins.

## Timing
- Output latency is 1 cycle: r/g/b at edge N+1 reflect x,y sampled at edge N.
- r/g/b reset value is 0.
- The latched position updates at the tick edge, so pixel (0,0) of a new frame renders with the previous frame's position. Every pixel after it uses the new position.
- State changes take effect on the pixel sampled the cycle after the event.
- reset mid-frame: outputs 0 next cycle, pos_valid=0, and the sprite stays black until the next tick.
- Fright duration is exactly FRIGHT_FRAMES unheld ticks from e_fright to NORMAL, with the last WARN_FRAMES of them spent in WARN.

## Test plan
- **Normal render:** defaults, xGhost=100, yGhost=50, one tick, then scan rows 49–51.
  - Required: (255,0,0) for x=99..101 on those rows, one cycle after each sample.
  - Required: (0,0,0) at x=98 and x=102.
- **Edge clipping:** HALF=2, xGhost=0, yGhost=0.
  - Required: hit for x=0..2, y=0..2.
  - Required: no hit at x=1022 (no wrap).
  - Required: pixel (0,0) of the first frame is black because pos_valid is still 0.
- **Fright/warn/blink:** FRIGHT_FRAMES=6, WARN_FRAMES=4, BLINK_FRAMES=1; e_fright, then ticks.
  - Required: blue for ticks 1–2.
  - Required: WARN from tick 2 with phase blue, white, blue, white on successive ticks.
  - Required: NORMAL red after tick 6.
- **Hold:** m_hold=1 during 3 ticks in FRIGHT.
  - Required: cnt unchanged.
  - Required: xGhost changes are still picked up at each tick.
- **Eaten:** e_eaten in WARN.
  - Required: only (xl±HALF, yl−HALF) are white.
  - Required: e_fright is ignored while EATEN.
  - Required: e_home returns the ghost to red body.
- **Collisions/reset:**
  - e_fright same cycle as tick → cnt=FRIGHT_FRAMES.
  - e_eaten+e_fright in FRIGHT → EATEN.
  - reset mid-scanline → r=g=b=0 next cycle, state NORMAL.
